// File: rtl/sync_fifo_pkg.sv
// Shared constants, depth helper and pointer type for the sync_fifo block.
package sync_fifo_pkg;

  localparam int unsigned DEFAULT_WIDTH     = 32;
  localparam int unsigned DEFAULT_DEPTH_LEN = 4;

  function automatic int unsigned fifo_depth(input int unsigned len);
    return 32'd1 << len;
  endfunction

  // Pointer carries one extra wrap bit above the address bits.
  typedef logic [DEFAULT_DEPTH_LEN:0] ptr_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// 1-write/1-read register array with synchronous write and registered read port.
module sync_fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned DEPTH_LEN = DEFAULT_DEPTH_LEN
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 wr_en,
  input  logic [DEPTH_LEN-1:0] wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 rd_en,
  input  logic [DEPTH_LEN-1:0] rd_addr,
  output logic [WIDTH-1:0]     rd_data
);

  localparam int unsigned DEPTH = fifo_depth(DEPTH_LEN);

  logic [WIDTH-1:0] mem [0:DEPTH-1];

  // Storage is intentionally left unreset; only the read register clears.
  always_ff @(posedge i_clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, full/empty flags, optional assertions (SYNC_FIFO_SVA_EN).
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned DEPTH_LEN = DEFAULT_DEPTH_LEN
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_data,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  logic [DEPTH_LEN:0] wptr;
  logic [DEPTH_LEN:0] rptr;
  logic               wr_ok;
  logic               rd_ok;

  always_comb begin
    o_empty = (wptr == rptr);
    o_full  = (wptr[DEPTH_LEN-1:0] == rptr[DEPTH_LEN-1:0]) &&
              (wptr[DEPTH_LEN] != rptr[DEPTH_LEN]);
    wr_ok   = i_rst_n && wr_en && !o_full;
    rd_ok   = i_rst_n && rd_en && !o_empty;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
    end
  end

  sync_fifo_mem #(
    .WIDTH     (WIDTH),
    .DEPTH_LEN (DEPTH_LEN)
  ) u_mem (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .wr_en   (wr_ok),
    .wr_addr (wptr[DEPTH_LEN-1:0]),
    .wr_data (i_data),
    .rd_en   (rd_ok),
    .rd_addr (rptr[DEPTH_LEN-1:0]),
    .rd_data (o_data)
  );

`ifdef SYNC_FIFO_SVA_EN
  localparam logic [DEPTH_LEN:0] DEPTH_P = (DEPTH_LEN+1)'(fifo_depth(DEPTH_LEN));

  a_not_full_and_empty: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    !(o_full && o_empty));

  a_overflow_stable: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (wr_en && o_full) |=> (wptr == $past(wptr)));

  a_underflow_stable: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (rd_en && o_empty) |=> (rptr == $past(rptr)));

  a_occupancy: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    ((DEPTH_LEN+1)'(wptr - rptr) <= DEPTH_P));

  a_reset_flags: assert property (@(posedge i_clk)
    !i_rst_n |=> (o_empty && !o_full));
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Randomised and directed checks of sync_fifo against a queue-based reference.
module tb_sync_fifo;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned DEPTH_LEN = 4;
  localparam int unsigned DEPTH     = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             wr = 1'b0;
  logic             rd = 1'b0;
  logic [WIDTH-1:0] dout;
  logic             full;
  logic             empty;

  int vectors = 0;
  int errors  = 0;

  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] exp_data = '0;
  bit               model_ok = 1'b0;

  sync_fifo #(
    .WIDTH     (WIDTH),
    .DEPTH_LEN (DEPTH_LEN)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_data  (din),
    .wr_en   (wr),
    .rd_en   (rd),
    .o_data  (dout),
    .o_full  (full),
    .o_empty (empty)
  );

  always #5 clk = ~clk;

  // Reference: a queue of stored words plus the last word handed out.
  always @(posedge clk) begin
    bit was_full;
    bit was_empty;
    if (!rst_n) begin
      q.delete();
      exp_data = '0;
      model_ok = 1'b1;
    end else begin
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      if (rd && !was_empty) exp_data = q.pop_front();
      if (wr && !was_full)  q.push_back(din);
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      vectors++;
      if (empty !== (q.size() == 0) || full !== (q.size() == DEPTH) || dout !== exp_data) begin
        errors++;
        $display("FAIL cycle_compare t=%0t: got empty=%0b full=%0b data=%h, want empty=%0b full=%0b data=%h",
                 $time, empty, full, dout, (q.size() == 0), (q.size() == DEPTH), exp_data);
      end
    end
  end

  task automatic check(input string name, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] want);
    vectors++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic step(input bit r_n, input bit w, input bit r, input logic [WIDTH-1:0] d);
    @(negedge clk);
    rst_n = r_n;
    wr    = w;
    rd    = r;
    din   = d;
    @(posedge clk);
    #1;
  endtask

  logic [WIDTH-1:0] sent[$];
  logic [WIDTH-1:0] last_w;

  initial begin
    // Reset held for 10 cycles
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, '0);
    check("reset_empty", 32'(empty), 32'd1);
    check("reset_full",  32'(full),  32'd0);
    check("reset_data",  dout,       32'd0);

    // Fill with 0..15, then an overflow write
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'(i));
      if (i == 14) check("almost_full", 32'(full), 32'd0);
    end
    check("fill_full",  32'(full),  32'd1);
    check("fill_empty", 32'(empty), 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'hA5);
    check("overflow_full", 32'(full), 32'd1);

    // Drain 17 times; the last read is an underflow
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 1'b0, 1'b1, '0);
      if (i < 16) check($sformatf("drain_%0d", i), dout, 32'(i));
    end
    check("drain_empty",     32'(empty), 32'd1);
    check("underflow_hold",  dout,       32'h0000000F);

    // Wrap: 10 in/10 out twice, pointers cross the wrap boundary
    for (int pass = 0; pass < 2; pass++) begin
      sent.delete();
      for (int i = 0; i < 10; i++) begin
        last_w = $urandom;
        sent.push_back(last_w);
        step(1'b1, 1'b1, 1'b0, last_w);
      end
      for (int i = 0; i < 10; i++) begin
        step(1'b1, 1'b0, 1'b1, '0);
        check($sformatf("wrap%0d_%0d", pass, i), dout, sent[i]);
      end
    end
    check("wrap_empty", 32'(empty), 32'd1);

    // Simultaneous read/write with 3 entries held
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 32'h100 + 32'(i));
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 1'b1, 32'h200 + 32'(i));
      check($sformatf("simul_data_%0d", i), dout, (i < 3) ? 32'h100 + 32'(i) : 32'h200 + 32'(i - 3));
    end
    check("simul_occupancy", 32'(q.size()), 32'd3);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, '0);
    check("simul_drain_last", dout, 32'h200 + 32'd19);
    check("simul_drained", 32'(empty), 32'd1);
    step(1'b1, 1'b1, 1'b1, 32'hBEEF);
    check("empty_wr_rd_data",  dout, 32'h200 + 32'd19);
    check("empty_wr_rd_empty", 32'(empty), 32'd0);
    step(1'b1, 1'b0, 1'b1, '0);
    check("empty_wr_rd_word", dout, 32'hBEEF);

    // Mid-operation reset with 5 entries
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 32'h300 + 32'(i));
    step(1'b0, 1'b0, 1'b0, '0);
    check("midrst_empty", 32'(empty), 32'd1);
    check("midrst_full",  32'(full),  32'd0);
    step(1'b1, 1'b1, 1'b0, 32'h1234);
    step(1'b1, 1'b0, 1'b1, '0);
    check("midrst_new_word", dout, 32'h1234);

    // Random traffic with occasional resets; cycle compare covers it
    for (int i = 0; i < 3000; i++) begin
      int unsigned mode;
      mode = (i / 500) % 3;
      step(($urandom_range(0, 199) != 0),
           (mode == 1) ? ($urandom_range(0, 3) != 0) : (mode == 2) ? ($urandom_range(0, 3) == 0) : 1'($urandom),
           (mode == 2) ? ($urandom_range(0, 3) != 0) : (mode == 1) ? ($urandom_range(0, 3) == 0) : 1'($urandom),
           $urandom);
    end

    step(1'b1, 1'b0, 1'b0, '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
